// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: monitors a multiplexed 4-digit 7-segment bus and turns
// each scanned digit back into a nibble. It assembles complete frames and
// flags undecodable glyphs, multi-hot selects and frame timeouts.
module seg_scan_decoder #(
  parameter int STABLE_CYC = 4,
  parameter int TO_W       = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  digit_sel,
  input  logic [7:0]  seg,
  output logic [15:0] frame_bcd,
  output logic [3:0]  frame_dp,
  output logic [3:0]  frame_blank,
  output logic        frame_err,
  output logic        frame_valid,
  output logic        timeout
);

  localparam int              CNT_W   = $clog2(STABLE_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC - 1);
  localparam logic [TO_W-1:0]  TO_MAX  = '1;

  typedef enum logic {S_TRACK, S_HELD} state_t;

  state_t            state, state_next;
  logic [3:0]        sel_s1, sel_s2, sel_p;
  logic [7:0]        seg_s1, seg_s2, seg_p;
  logic [CNT_W-1:0]  cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [3:0]        mask, mask_next;
  logic [15:0]       shadow_bcd, bcd_next;
  logic [3:0]        dp_sh, dp_next;
  logic [3:0]        blank_sh, blank_next;
  logic              err_sh, err_next;
  logic              changed, stable, one_hot, capture, multi_err;
  logic              complete, to_hit, clear;
  logic [1:0]        sel_idx;
  logic [3:0]        glyph_val;
  logic              glyph_blank, glyph_bad;

  // Two-flop synchronizers for the asynchronous display bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_s1 <= '0;
      sel_s2 <= '0;
      seg_s1 <= '0;
      seg_s2 <= '0;
    end else begin
      sel_s1 <= digit_sel;
      sel_s2 <= sel_s1;
      seg_s1 <= seg;
      seg_s2 <= seg_s1;
    end
  end

  assign changed = ({sel_s2, seg_s2} != {sel_p, seg_p});
  assign stable  = (cnt == CNT_MAX) && !changed;
  assign one_hot = (sel_s2 != 4'b0) && ((sel_s2 & (sel_s2 - 4'd1)) == 4'b0);

  // Stability counter: counts consecutive identical synchronized samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_p <= '0;
      seg_p <= '0;
      cnt   <= '0;
    end else begin
      sel_p <= sel_s2;
      seg_p <= seg_s2;
      if (changed)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
    end
  end

  // Capture FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_TRACK;
    else
      state <= state_next;
  end

  // Capture FSM: one capture per stable dwell, re-armed by any bus change.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    multi_err  = 1'b0;
    case (state)
      S_TRACK: begin
        if (stable && (sel_s2 != 4'b0)) begin
          state_next = S_HELD;
          if (one_hot)
            capture = 1'b1;
          else
            multi_err = 1'b1;
        end
      end
      S_HELD: begin
        if (changed)
          state_next = S_TRACK;
      end
      default: state_next = S_TRACK;
    endcase
  end

  // One-hot select to digit index.
  always_comb begin
    sel_idx = 2'd0;
    case (sel_s2)
      4'b0010: sel_idx = 2'd1;
      4'b0100: sel_idx = 2'd2;
      4'b1000: sel_idx = 2'd3;
      default: sel_idx = 2'd0;
    endcase
  end

  // Glyph decode of segments a..g back to a nibble.
  always_comb begin
    glyph_val   = 4'hE;
    glyph_blank = 1'b0;
    glyph_bad   = 1'b0;
    case (seg_s2[7:1])
      7'b1111110: glyph_val = 4'h0;
      7'b0110000: glyph_val = 4'h1;
      7'b1101101: glyph_val = 4'h2;
      7'b1111001: glyph_val = 4'h3;
      7'b0110011: glyph_val = 4'h4;
      7'b1011011: glyph_val = 4'h5;
      7'b1011111: glyph_val = 4'h6;
      7'b1110000: glyph_val = 4'h7;
      7'b1111111: glyph_val = 4'h8;
      7'b1111011: glyph_val = 4'h9;
      7'b1000111: glyph_val = 4'hF;
      7'b1001110: glyph_val = 4'hC;
      7'b0000000: begin
        glyph_val   = 4'hA;
        glyph_blank = 1'b1;
      end
      default: begin
        glyph_val = 4'hE;
        glyph_bad = 1'b1;
      end
    endcase
  end

  assign complete = (mask == 4'b1111);
  assign to_hit   = !complete && (to_cnt == TO_MAX - 1'b1);
  assign clear    = complete || to_hit;

  // Next shadow state: frame close/timeout clears first, then a capture lands in the new frame.
  always_comb begin
    mask_next  = clear ? 4'b0 : mask;
    blank_next = clear ? 4'b0 : blank_sh;
    err_next   = clear ? 1'b0 : err_sh;
    bcd_next   = shadow_bcd;
    dp_next    = dp_sh;
    if (multi_err)
      err_next = 1'b1;
    if (capture) begin
      mask_next[sel_idx]  = 1'b1;
      blank_next[sel_idx] = glyph_blank;
      dp_next[sel_idx]    = seg_s2[0];
      bcd_next[{sel_idx, 2'b00} +: 4] = glyph_val;
      if (glyph_bad)
        err_next = 1'b1;
    end
  end

  // Shadow registers, frame outputs and the sticky frame timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask        <= '0;
      shadow_bcd  <= '0;
      dp_sh       <= '0;
      blank_sh    <= '0;
      err_sh      <= 1'b0;
      to_cnt      <= '0;
      timeout     <= 1'b0;
      frame_bcd   <= '0;
      frame_dp    <= '0;
      frame_blank <= '0;
      frame_err   <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      mask        <= mask_next;
      shadow_bcd  <= bcd_next;
      dp_sh       <= dp_next;
      blank_sh    <= blank_next;
      err_sh      <= err_next;
      frame_valid <= complete;
      if (complete) begin
        frame_bcd   <= shadow_bcd;
        frame_dp    <= dp_sh;
        frame_blank <= blank_sh;
        frame_err   <= err_sh;
        to_cnt      <= '0;
        timeout     <= 1'b0;
      end else if (to_cnt != TO_MAX) begin
        to_cnt <= to_cnt + 1'b1;
        if (to_hit)
          timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed self-checking bench for seg_scan_decoder,
// using a short timeout width so the timeout path is reachable quickly.
module tb_seg_scan_decoder;

  localparam logic [7:0] G0    = 8'hFC;
  localparam logic [7:0] G2    = 8'hDA;
  localparam logic [7:0] G3    = 8'hF2;
  localparam logic [7:0] G5    = 8'hB6;
  localparam logic [7:0] G7    = 8'hE0;
  localparam logic [7:0] G8    = 8'hFE;
  localparam logic [7:0] G9    = 8'hF6;
  localparam logic [7:0] GF    = 8'h8E;
  localparam logic [7:0] GC    = 8'h9C;
  localparam logic [7:0] GBLK  = 8'h00;
  localparam logic [7:0] GBAD  = 8'b01010100;

  logic        clk;
  logic        rst_n;
  logic [3:0]  digit_sel;
  logic [7:0]  seg;
  logic [15:0] frame_bcd;
  logic [3:0]  frame_dp;
  logic [3:0]  frame_blank;
  logic        frame_err;
  logic        frame_valid;
  logic        timeout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fv_count = 0;
  int fv_cyc = 0;
  int to_cyc = 0;
  bit to_seen = 0;
  int base;

  seg_scan_decoder #(.STABLE_CYC(4), .TO_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .digit_sel(digit_sel),
    .seg(seg),
    .frame_bcd(frame_bcd),
    .frame_dp(frame_dp),
    .frame_blank(frame_blank),
    .frame_err(frame_err),
    .frame_valid(frame_valid),
    .timeout(timeout)
  );

  // Free-running clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record frame_valid pulses and the first timeout assertion.
  always @(negedge clk) begin
    if (frame_valid) begin
      fv_count = fv_count + 1;
      fv_cyc   = cyc;
    end
    if (timeout && !to_seen) begin
      to_seen = 1;
      to_cyc  = cyc;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks = checks + 1;
    if (observed !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] s, input logic [7:0] g, input int n);
    digit_sel = s;
    seg       = g;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scanFrame(input logic [7:0] g0, input logic [7:0] g1,
                           input logic [7:0] g2, input logic [7:0] g3);
    applyStimulus(4'b0001, g0, 8);
    applyStimulus(4'b0010, g1, 8);
    applyStimulus(4'b0100, g2, 8);
    applyStimulus(4'b1000, g3, 8);
    applyStimulus(4'b0000, 8'h00, 4);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    digit_sel = 4'b0;
    seg       = 8'h00;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_bcd", 32'(frame_bcd), 32'h0);
    checkOutput("rst_dp", 32'(frame_dp), 32'h0);
    checkOutput("rst_blank", 32'(frame_blank), 32'h0);
    checkOutput("rst_err", 32'(frame_err), 32'h0);
    checkOutput("rst_valid", 32'(frame_valid), 32'h0);
    checkOutput("rst_timeout", 32'(timeout), 32'h0);
    rst_n = 1'b1;
    applyStimulus(4'b0000, 8'h00, 3);

    // Frame 'hCC20 with dp on digit 1.
    base = fv_count;
    scanFrame(G0, G2 | 8'h01, GC, GC);
    checkOutput("t1_fv", 32'(fv_count - base), 32'd1);
    checkOutput("t1_bcd", 32'(frame_bcd), 32'hCC20);
    checkOutput("t1_dp", 32'(frame_dp), 32'b0010);
    checkOutput("t1_blank", 32'(frame_blank), 32'h0);
    checkOutput("t1_err", 32'(frame_err), 32'h0);
    checkOutput("t1_timeout", 32'(timeout), 32'h0);

    // Dwell too short to capture; timeout exactly 255 cycles after last frame.
    base = fv_count;
    for (int r = 0; r < 50 && !to_seen; r++) begin
      applyStimulus(4'b0001, G0, 2);
      applyStimulus(4'b0010, G3, 2);
      applyStimulus(4'b0100, G5, 2);
      applyStimulus(4'b1000, G8, 2);
    end
    applyStimulus(4'b0000, 8'h00, 2);
    checkOutput("t2_to_seen", 32'(to_seen), 32'd1);
    checkOutput("t2_to_latency", 32'(to_cyc - fv_cyc), 32'd255);
    checkOutput("t2_timeout", 32'(timeout), 32'd1);
    checkOutput("t2_no_fv", 32'(fv_count - base), 32'd0);
    checkOutput("t2_bcd_kept", 32'(frame_bcd), 32'hCC20);

    // Undecodable glyph on digit 2.
    base = fv_count;
    scanFrame(G3, G5, GBAD, G0);
    checkOutput("t3_fv", 32'(fv_count - base), 32'd1);
    checkOutput("t3_bcd", 32'(frame_bcd), 32'h0E53);
    checkOutput("t3_err", 32'(frame_err), 32'd1);
    checkOutput("t3_timeout_clr", 32'(timeout), 32'd0);

    // Blank digit 3; clean frame clears the error.
    base = fv_count;
    scanFrame(G0, G3, G5, GBLK);
    checkOutput("t4_fv", 32'(fv_count - base), 32'd1);
    checkOutput("t4_bcd", 32'(frame_bcd), 32'hA530);
    checkOutput("t4_blank", 32'(frame_blank), 32'b1000);
    checkOutput("t4_err", 32'(frame_err), 32'd0);

    // Multi-hot select held stable, then a valid scan.
    base = fv_count;
    applyStimulus(4'b0110, G8, 10);
    checkOutput("t5_multi_no_fv", 32'(fv_count - base), 32'd0);
    scanFrame(G7, G8, G9, GF);
    checkOutput("t5_fv", 32'(fv_count - base), 32'd1);
    checkOutput("t5_bcd", 32'(frame_bcd), 32'hF987);
    checkOutput("t5_err", 32'(frame_err), 32'd1);

    // Reset after three captures, then a full new scan of 'h0035.
    base = fv_count;
    applyStimulus(4'b0001, G0, 8);
    applyStimulus(4'b0010, G3, 8);
    applyStimulus(4'b0100, G5, 8);
    digit_sel = 4'b0;
    seg       = 8'h00;
    rst_n     = 1'b0;
    #1;
    checkOutput("t6_rst_bcd", 32'(frame_bcd), 32'h0);
    checkOutput("t6_rst_err", 32'(frame_err), 32'h0);
    checkOutput("t6_rst_valid", 32'(frame_valid), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(4'b0000, 8'h00, 3);
    applyStimulus(4'b0001, G5, 8);
    applyStimulus(4'b0010, G3, 8);
    applyStimulus(4'b0100, G0, 8);
    applyStimulus(4'b0000, 8'h00, 4);
    checkOutput("t6_partial_no_fv", 32'(fv_count - base), 32'd0);
    applyStimulus(4'b1000, G0, 8);
    applyStimulus(4'b0000, 8'h00, 4);
    checkOutput("t6_fv", 32'(fv_count - base), 32'd1);
    checkOutput("t6_bcd", 32'(frame_bcd), 32'h0035);
    checkOutput("t6_err", 32'(frame_err), 32'd0);
    checkOutput("t6_dp", 32'(frame_dp), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
